// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches under a
// credit limit, and buffers {inst, pc} for decode behind a valid/ready port.
module if_fetch #(
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       INST_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_resp_valid_i,
  input  logic [INST_W-1:0] imem_resp_inst_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

  logic [1:0]        rst_sync_q;
  logic              rst_n_int;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  fifo_wr_q, fifo_wr_d;
  logic [PTR_W-1:0]  fifo_rd_q, fifo_rd_d;
  logic [PTR_W-1:0]  pcq_wr_q, pcq_wr_d;
  logic [PTR_W-1:0]  pcq_rd_q, pcq_rd_d;
  logic [ADDR_W-1:0] pc_hold_q, pc_hold_d;

  logic [INST_W-1:0] fifo_inst_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0] pcq_q       [FIFO_DEPTH];

  logic [CNT_W:0]    in_use;
  logic              credit_ok;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Reset synchroniser: assert immediately, release two clocks later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  // Handshake qualifiers and decode-facing outputs
  always_comb begin
    in_use           = {1'b0, fifo_cnt_q} + {1'b0, out_cnt_q};
    credit_ok        = in_use < (CNT_W + 1)'(FIFO_DEPTH);
    imem_req_valid_o = rst_n_int && !redirect_i && credit_ok;
    imem_req_addr_o  = fetch_pc_q;
    req_fire         = imem_req_valid_o && imem_req_ready_i;
    fifo_empty       = (fifo_cnt_q == '0);
    fifo_full        = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    valid_o          = !fifo_empty;
    inst_o           = fifo_empty ? NOP : fifo_inst_q[fifo_rd_q];
    pc_o             = fifo_empty ? pc_hold_q : fifo_pc_q[fifo_rd_q];
    push             = imem_resp_valid_i && !redirect_i && (drop_cnt_q == '0);
    pop              = valid_o && ready_i && !redirect_i;
  end

  // Next-state: PC, credit counters, drop counter and queue pointers
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    fifo_wr_d  = push ? ptr_inc(fifo_wr_q) : fifo_wr_q;
    fifo_rd_d  = pop ? ptr_inc(fifo_rd_q) : fifo_rd_q;
    out_cnt_d  = out_cnt_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid_i);
    pcq_wr_d   = req_fire ? ptr_inc(pcq_wr_q) : pcq_wr_q;
    pcq_rd_d   = imem_resp_valid_i ? ptr_inc(pcq_rd_q) : pcq_rd_q;
    pc_hold_d  = pc_o;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
      // Every request still in flight is stale, including ones already marked
      // for dropping, so the drop count becomes the remaining outstanding total.
      drop_cnt_d = out_cnt_q - CNT_W'(imem_resp_valid_i);
      fifo_cnt_d = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (imem_resp_valid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
      pc_hold_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
      pc_hold_q  <= pc_hold_d;
    end
  end

  // Data storage: instruction buffer and the PC-of-request queue
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[fifo_wr_q] <= imem_resp_inst_i;
      fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
    end
    if (req_fire) pcq_q[pcq_wr_q] <= fetch_pc_q;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n_int)
    !(push && fifo_full));

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a latency-configurable in-order memory and
// a queue-based reference of which PCs decode must see, in what order.
module tb_if_fetch;

  localparam int unsigned DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [63:0] imem_req_addr_o;
  logic        imem_resp_valid_i = 1'b0;
  logic [31:0] imem_resp_inst_i = '0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        valid_o;
  logic        ready_i = 1'b0;

  if_fetch #(
    .ADDR_W    (64),
    .INST_W    (32),
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i),
    .imem_resp_inst_i (imem_resp_inst_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] pc;
    int unsigned epoch;
    int unsigned due;
  } req_t;

  req_t        mem_q[$];
  logic [63:0] buf_q[$];
  int unsigned cyc = 0;
  int unsigned epoch = 0;
  int unsigned lat = 1;
  bit          mem_rdy_rand = 1'b0;
  logic [63:0] exp_req = RESET_PC;
  logic [63:0] last_pc = '0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit redir, input logic [63:0] tgt, input bit rdy);
    bit   resp;
    bit   exp_rv;
    bit   fire;
    req_t h;
    @(negedge clk);
    cyc++;
    redirect_i       = redir;
    redirect_pc_i    = tgt;
    ready_i          = rdy;
    imem_req_ready_i = mem_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    resp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    imem_resp_valid_i = resp;
    if (resp) imem_resp_inst_i = mem_q[0].addr[31:0];
    else      imem_resp_inst_i = $urandom;
    #1;
    exp_rv = !redir && ((mem_q.size() + buf_q.size()) < DEPTH);
    chk("req_valid", imem_req_valid_o, exp_rv);
    chk("req_addr", imem_req_addr_o, exp_req);
    chk("valid_o", valid_o, buf_q.size() != 0);
    if (buf_q.size() != 0) begin
      chk("pc_o", pc_o, buf_q[0]);
      chk("inst_o", inst_o, buf_q[0][31:0]);
      last_pc = buf_q[0];
    end else begin
      chk("pc_hold", pc_o, last_pc);
      chk("inst_nop", inst_o, NOP);
    end
    fire = imem_req_valid_o && imem_req_ready_i;
    if (resp) h = mem_q.pop_front();
    if (redir) begin
      buf_q.delete();
      epoch++;
      exp_req = {tgt[63:2], 2'b00};
    end else begin
      if (buf_q.size() != 0 && rdy) void'(buf_q.pop_front());
      if (resp && h.epoch == epoch) buf_q.push_back(h.pc);
    end
    if (fire) begin
      mem_q.push_back('{addr: imem_req_addr_o, pc: exp_req, epoch: epoch, due: cyc + lat});
      exp_req += 64'd4;
    end
  endtask

  task automatic do_reset();
    bit seen;
    @(negedge clk);
    rst = 1'b0;
    redirect_i = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_req_ready_i = 1'b0;
    ready_i = 1'b0;
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_inst_o", inst_o, NOP);
    chk("rst_pc_o", pc_o, 0);
    chk("rst_req_valid", imem_req_valid_o, 0);
    chk("rst_req_addr", imem_req_addr_o, RESET_PC);
    mem_q.delete();
    buf_q.delete();
    exp_req = RESET_PC;
    last_pc = '0;
    epoch++;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!seen) begin
        #1;
        seen = (imem_req_valid_o === 1'b1);
        if (!seen) @(negedge clk);
      end
    end
    chk("rst_release_req", seen, 1);
    chk("rst_release_addr", imem_req_addr_o, RESET_PC);
    chk("rst_release_valid_o", valid_o, 0);
  endtask

  initial begin
    // Power-on reset, then a 1-cycle-latency stream with decode always ready
    do_reset();
    lat = 1;
    mem_rdy_rand = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);

    // Decode stall: buffer fills, requests stop, then drains in order
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
    chk("stall_buffer_full", valid_o, 1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);

    // Redirect with two requests in flight (3-cycle memory)
    lat = 3;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) step(1'b0, '0, 1'b1);
    chk("c_two_outstanding", mem_q.size(), 2);
    step(1'b1, 64'h0000_0000_8000_1002, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);

    // Redirect coinciding with a response, one more still outstanding
    lat = 2;
    for (int i = 0; i < 30 && !(mem_q.size() == 2 && mem_q[0].due <= cyc + 1); i++)
      step(1'b0, '0, 1'b1);
    chk("d_resp_and_one_more", (mem_q.size() == 2 && mem_q[0].due <= cyc + 1), 1);
    step(1'b1, 64'h0000_0000_8000_2000, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

    // Address wrap past all-ones
    lat = 1;
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

    // Random traffic: back-pressure on both sides, varying latency, redirects
    mem_rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) lat = $urandom_range(1, 4);
      step(($urandom_range(0, 24) == 0), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    end
    mem_rdy_rand = 1'b0;

    // Reset mid-stream with a full buffer
    lat = 1;
    for (int i = 0; i < 40 && buf_q.size() < 2; i++) step(1'b0, '0, 1'b0);
    chk("g_buffer_full", valid_o, 1);
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
